// File: rtl/dc_log_reader.sv
// Data-checker log RAM (DEPTH x 288b) with write statistics and a 32-bit word readback.
// First word 3 cycles after rd_start; rd_data/rd_valid hold while rd_ready=0.
module dc_log_reader #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dc_mem_we,
  input  logic [AW-1:0] dc_mem_addr,
  input  logic [287:0]  dc_mem_din,
  input  logic          log_clr,
  input  logic          rd_start,
  input  logic [AW-1:0] rd_base,
  input  logic [AW:0]   rd_count,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          rd_busy,
  output logic          rd_done,
  output logic [AW:0]   wr_count,
  output logic [AW:0]   hwm
);
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
  localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, STREAM, DONE} state_t;

  state_t           state_q;
  logic             req_q;
  logic [AW-1:0]    base_q;
  logic [AW:0]      cnt_q;
  logic [AW-1:0]    ptr_q;
  logic [AW:0]      rem_q;
  logic [3:0]       idx_q;
  logic [8:0][31:0] entry_q;
  logic [287:0]     ram_dout_q;
  logic [31:0]      rd_data_q;
  logic             rd_valid_q, rd_busy_q, rd_done_q;
  logic [AW:0]      wr_count_q, wr_count_d;
  logic [AW:0]      hwm_q, hwm_d;
  logic [AW:0]      addr_p1;

  logic [287:0] mem [DEPTH];

  // Read-first: the read sees the entry as it was before a same-edge write.
  always_ff @(posedge clk) begin
    if (dc_mem_we) mem[dc_mem_addr] <= dc_mem_din;
    ram_dout_q <= mem[ptr_q];
  end

  always_comb begin
    wr_count_d = wr_count_q;
    hwm_d      = hwm_q;
    addr_p1    = {1'b0, dc_mem_addr} + ONE_W;
    if (log_clr) begin
      wr_count_d = '0;
      hwm_d      = '0;
    end else if (dc_mem_we) begin
      if (wr_count_q != DEPTH_W) wr_count_d = wr_count_q + ONE_W;
      if (addr_p1 > hwm_q) hwm_d = addr_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_count_q <= '0;
      hwm_q      <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      hwm_q      <= hwm_d;
    end
  end

  // rd_start is registered into req_q first; IDLE acts on it the following edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      base_q     <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      entry_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_busy_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      rd_done_q <= 1'b0;
      req_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_q) begin
            ptr_q     <= base_q;
            rem_q     <= cnt_q;
            rd_busy_q <= 1'b1;
            if (cnt_q == '0) begin
              state_q   <= DONE;
              rd_done_q <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end else if (rd_start) begin
            req_q  <= 1'b1;
            base_q <= rd_base;
            cnt_q  <= rd_count;
          end
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          entry_q    <= ram_dout_q;
          rd_data_q  <= ram_dout_q[31:0];
          rd_valid_q <= 1'b1;
          idx_q      <= '0;
          state_q    <= STREAM;
        end
        STREAM: begin
          if (rd_ready) begin
            if (idx_q == 4'd8) begin
              rd_valid_q <= 1'b0;
              ptr_q      <= ptr_q + 1'b1;
              rem_q      <= rem_q - ONE_W;
              if (rem_q == ONE_W) begin
                state_q   <= DONE;
                rd_done_q <= 1'b1;
              end else begin
                state_q <= FETCH;
              end
            end else begin
              idx_q     <= idx_q + 4'd1;
              rd_data_q <= entry_q[idx_q + 4'd1];
            end
          end
        end
        DONE: begin
          rd_busy_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_busy  = rd_busy_q;
  assign rd_done  = rd_done_q;
  assign wr_count = wr_count_q;
  assign hwm      = hwm_q;
endmodule

// File: tb/tb_dc_log_reader.sv
// Bench for dc_log_reader: transaction-level model (RAM image, word queue, latency
// counters, statistics) compared every cycle, plus directed literal checks.
module tb_dc_log_reader;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dc_mem_we;
  logic [AW-1:0] dc_mem_addr;
  logic [287:0]  dc_mem_din;
  logic          log_clr;
  logic          rd_start;
  logic [AW-1:0] rd_base;
  logic [AW:0]   rd_count;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_busy;
  logic          rd_done;
  logic [AW:0]   wr_count;
  logic [AW:0]   hwm;

  dc_log_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .dc_mem_we(dc_mem_we), .dc_mem_addr(dc_mem_addr), .dc_mem_din(dc_mem_din),
    .log_clr(log_clr), .rd_start(rd_start), .rd_base(rd_base), .rd_count(rd_count),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_busy(rd_busy), .rd_done(rd_done), .wr_count(wr_count), .hwm(hwm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [287:0] pat(input int e);
    logic [287:0] r;
    r = '0;
    for (int w = 0; w < 9; w++) r[32*w +: 32] = 32'h5A00_0000 | 32'(e * 16 + w);
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic [287:0] mm [int];
  logic [31:0]  m_q[$];
  int  m_wr, m_hwm;
  bit  m_active, m_pending, exp_valid, exp_busy, exp_done, m_first_pend;
  int  m_wait, m_ent_left, m_word, m_xfers;
  logic [31:0] m_first;

  always @(posedge clk) begin
    bit was_active;
    if (!rst_n) begin
      m_wr = 0; m_hwm = 0;
      m_q.delete();
      m_active = 0; m_pending = 0; exp_valid = 0; exp_busy = 0; exp_done = 0;
    end else begin
      if (log_clr) begin
        m_wr = 0; m_hwm = 0;
      end else if (dc_mem_we) begin
        if (m_wr < DEPTH) m_wr++;
        if (int'(dc_mem_addr) + 1 > m_hwm) m_hwm = int'(dc_mem_addr) + 1;
      end
      if (dc_mem_we) mm[int'(dc_mem_addr)] = dc_mem_din;

      was_active = m_active;
      if (exp_done) begin
        exp_done = 0; exp_busy = 0; m_active = 0;
      end else if (m_active) begin
        if (m_pending) begin
          m_pending = 0; exp_busy = 1;
        end
        if (exp_valid && rd_ready) begin
          if (m_first_pend) begin m_first = m_q[0]; m_first_pend = 0; end
          void'(m_q.pop_front());
          m_xfers++;
          m_word++;
          if (m_word == 9) begin
            m_word = 0;
            m_ent_left--;
            exp_valid = 0;
            if (m_ent_left == 0) exp_done = 1;
            else m_wait = 2;
          end
        end else if (!exp_valid) begin
          m_wait--;
          if (m_wait == 0) begin
            if (m_ent_left == 0) exp_done = 1;
            else exp_valid = 1;
          end
        end
      end
      if (rd_start && !was_active) begin
        m_active = 1; m_pending = 1; m_word = 0; m_first_pend = 1;
        m_ent_left = int'(rd_count);
        m_wait = (rd_count == 0) ? 1 : 3;
        for (int e = 0; e < int'(rd_count); e++) begin
          logic [287:0] ent;
          ent = mm[(int'(rd_base) + e) % DEPTH];
          for (int w = 0; w < 9; w++) m_q.push_back(ent[32*w +: 32]);
        end
      end
    end
    #1;
    if (chk_en) begin
      chk("rd_valid", 64'(rd_valid), 64'(exp_valid));
      if (exp_valid && m_q.size() > 0) chk("rd_data", 64'(rd_data), 64'(m_q[0]));
      chk("rd_busy", 64'(rd_busy), 64'(exp_busy));
      chk("rd_done", 64'(rd_done), 64'(exp_done));
      chk("wr_count", 64'(wr_count), 64'(m_wr));
      chk("hwm", 64'(hwm), 64'(m_hwm));
    end
  end

  // ---------------- stimulus (tasks start and end on a negedge) ----------------
  task automatic wr(input int a, input logic [287:0] d);
    dc_mem_we = 1'b1; dc_mem_addr = AW'(a); dc_mem_din = d;
    @(negedge clk);
    dc_mem_we = 1'b0;
  endtask

  task automatic start(input int b, input int c);
    rd_start = 1'b1; rd_base = AW'(b); rd_count = (AW+1)'(c);
    @(negedge clk);
    rd_start = 1'b0;
  endtask

  task automatic run_until_idle(input bit rnd);
    int n = 0;
    while (m_active && n < 2000) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n++;
    end
    rd_ready = 1'b1;
    chk("readback_timeout", 64'(n >= 2000), 64'(0));
    chk("queue_drained", 64'(m_q.size()), 64'(0));
  endtask

  initial begin
    int x0, n;
    rst_n = 1'b0; dc_mem_we = 1'b0; dc_mem_addr = '0; dc_mem_din = '0;
    log_clr = 1'b0; rd_start = 1'b0; rd_base = '0; rd_count = '0; rd_ready = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    chk("rst_rd_busy", 64'(rd_busy), 64'(0));
    chk("rst_rd_done", 64'(rd_done), 64'(0));
    chk("rst_wr_count", 64'(wr_count), 64'(0));
    chk("rst_hwm", 64'(hwm), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // four entries streamed with no backpressure
    for (int i = 0; i < 4; i++) wr(i, pat(i));
    x0 = m_xfers;
    start(0, 4);
    run_until_idle(1'b0);
    chk("basic_xfers", 64'(m_xfers - x0), 64'(36));
    chk("basic_word0", 64'(m_first), 64'(32'h5A00_0000));
    chk("basic_wr_count", 64'(wr_count), 64'(4));
    chk("basic_hwm", 64'(hwm), 64'(4));

    // random backpressure over two entries
    x0 = m_xfers;
    start(1, 2);
    run_until_idle(1'b1);
    chk("bp_xfers", 64'(m_xfers - x0), 64'(18));
    chk("bp_word0", 64'(m_first), 64'(32'h5A00_0010));

    // wrap from the last entry to entry 0
    wr(DEPTH - 1, pat(DEPTH - 1));
    x0 = m_xfers;
    start(DEPTH - 1, 2);
    run_until_idle(1'b0);
    chk("wrap_xfers", 64'(m_xfers - x0), 64'(18));
    chk("wrap_word0", 64'(m_first), 64'(32'h5A00_FFF0));
    chk("wrap_hwm", 64'(hwm), 64'(DEPTH));

    // zero-length readback: done after two edges, no data
    start(5, 0);
    chk("cnt0_done_early", 64'(rd_done), 64'(0));
    @(negedge clk);
    chk("cnt0_done", 64'(rd_done), 64'(1));
    chk("cnt0_valid", 64'(rd_valid), 64'(0));
    run_until_idle(1'b0);

    // rd_start while busy must be ignored
    x0 = m_xfers;
    start(2, 1);
    @(negedge clk);
    start(0, 3);
    @(negedge clk);
    start(1, 2);
    run_until_idle(1'b0);
    chk("busy_ign_xfers", 64'(m_xfers - x0), 64'(9));
    chk("busy_ign_word0", 64'(m_first), 64'(32'h5A00_0020));

    // reset during STREAM aborts with no done; RAM survives
    start(0, 2);
    n = 0;
    while (!rd_valid && n < 50) begin @(negedge clk); n++; end
    chk("rstmid_valid_seen", 64'(n < 50), 64'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmid_valid", 64'(rd_valid), 64'(0));
    chk("rstmid_busy", 64'(rd_busy), 64'(0));
    chk("rstmid_done", 64'(rd_done), 64'(0));
    @(negedge clk);
    chk("rstmid_done_after", 64'(rd_done), 64'(0));
    x0 = m_xfers;
    start(3, 1);
    run_until_idle(1'b0);
    chk("rstmid_reread", 64'(m_first), 64'(32'h5A00_0030));
    chk("rstmid_xfers", 64'(m_xfers - x0), 64'(9));

    // statistics: hwm, clear-wins, saturation
    wr(10, pat(10));
    wr(3, pat(3));
    chk("stat_hwm11", 64'(hwm), 64'(11));
    chk("stat_wr2", 64'(wr_count), 64'(2));
    log_clr = 1'b1;
    wr(7, pat(7));
    log_clr = 1'b0;
    chk("clr_wr", 64'(wr_count), 64'(0));
    chk("clr_hwm", 64'(hwm), 64'(0));
    for (int i = 0; i < DEPTH + 5; i++) wr(i % DEPTH, 288'(i));
    chk("sat_wr_count", 64'(wr_count), 64'(DEPTH));
    chk("sat_hwm", 64'(hwm), 64'(DEPTH));
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
